// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller
package hazard_pkg;
    localparam int REG_AW_DEF = 4;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;
    typedef enum logic [1:0] {RUN, LSTALL, MWAIT} hz_state_t;
endpackage

// File: rtl/hazard_match.sv
// hazard_match: source/destination register compare with optional r0 mask
module hazard_match
    import hazard_pkg::*;
#(
    parameter int REG_AW     = REG_AW_DEF,
    parameter bit R0_IS_ZERO = 1'b1
) (
    input  logic              en,
    input  logic [REG_AW-1:0] src,
    input  logic [REG_AW-1:0] dst,
    output logic              hit
);
    assign hit = en && src == dst && !(R0_IS_ZERO && dst == '0);
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / memory-wait / branch-squash stall controller; HAZARD_STATS_EN adds stall and flush counters
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW     = REG_AW_DEF,
    parameter int LOAD_LAT   = 1,
    parameter bit R0_IS_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              ex_valid,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_wr_en,
    input  logic              branch_taken,
    input  logic              mem_busy,
    output logic              pc_hold,
    output logic              ifid_hold,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              exmem_hold,
    output logic              memwb_bubble,
    output logic              stall_active
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]       stall_cycles,
    output logic [15:0]       flush_count
`endif
);
    hz_state_t state, state_d, saved, saved_d, eff;
    logic [2:0] cnt, cnt_d;
    logic hit_rs, hit_rt, load_use;
    logic ph, ih, fl, ib, eh, mb;

    hazard_match #(.REG_AW(REG_AW), .R0_IS_ZERO(R0_IS_ZERO)) u_rs (
        .en(id_uses_rs), .src(id_rs), .dst(ex_rd), .hit(hit_rs)
    );
    hazard_match #(.REG_AW(REG_AW), .R0_IS_ZERO(R0_IS_ZERO)) u_rt (
        .en(id_uses_rt), .src(id_rt), .dst(ex_rd), .hit(hit_rt)
    );

    assign load_use = id_valid && ex_valid && ex_is_load && ex_wr_en && (hit_rs || hit_rt);
    // a memory wait resumes the saved state in its exit cycle, so it is evaluated as that state
    assign eff = state == MWAIT ? saved : state;

    // next state and stage controls, priority mem_busy > branch > countdown/load-use
    always_comb begin
        state_d = eff;
        saved_d = saved;
        cnt_d = cnt;
        {ph, ih, fl, ib, eh, mb} = '0;
        if (mem_busy) begin
            state_d = MWAIT;
            saved_d = eff;
            {ph, ih, eh, mb} = '1;
        end else if (branch_taken) begin
            state_d = RUN;
            cnt_d = '0;
            {fl, ib} = '1;
        end else if (eff == LSTALL) begin
            {ph, ih, ib} = '1;
            cnt_d = cnt - 3'd1;
            state_d = cnt == 3'd1 ? RUN : LSTALL;
        end else if (load_use) begin
            {ph, ih, ib} = '1;
            if (LOAD_LAT > 1) begin
                state_d = LSTALL;
                cnt_d = 3'(LOAD_LAT - 1);
            end
        end
    end

    // state, saved-state and bubble countdown registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            saved <= RUN;
            cnt <= '0;
        end else begin
            state <= state_d;
            saved <= saved_d;
            cnt <= cnt_d;
        end
    end

    assign pc_hold      = rst_n && ph;
    assign ifid_hold    = rst_n && ih;
    assign ifid_flush   = rst_n && fl;
    assign idex_bubble  = rst_n && ib;
    assign exmem_hold   = rst_n && eh;
    assign memwb_bubble = rst_n && mb;
    assign stall_active = rst_n && state != RUN;

`ifdef HAZARD_STATS_EN
    // saturating counters of held-PC cycles and IF/ID flush cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count <= '0;
        end else begin
            if (pc_hold && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
            if (ifid_flush && flush_count != 16'hFFFF) flush_count <= flush_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: randomized and directed bench for hazard_ctrl at LOAD_LAT=1 and LOAD_LAT=3 (HAZARD_STATS_EN aware)
module tb_hazard_ctrl;
    localparam int LAT [2] = '{1, 3};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic id_valid, id_uses_rs, id_uses_rt, ex_valid, ex_is_load, ex_wr_en, branch_taken, mem_busy;
    logic [3:0] id_rs, id_rt, ex_rd;
    logic [1:0] pc_hold, ifid_hold, ifid_flush, idex_bubble, exmem_hold, memwb_bubble, stall_active;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cycles [2];
    logic [15:0] flush_count [2];
`endif

    int checks = 0;
    int failures = 0;
    int owed [2];
    bit waiting [2];
    int stalls [2];
    int flushes [2];

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(4), .LOAD_LAT(1), .R0_IS_ZERO(1'b1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_valid(ex_valid),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_wr_en(ex_wr_en),
        .branch_taken(branch_taken), .mem_busy(mem_busy), .pc_hold(pc_hold[0]),
        .ifid_hold(ifid_hold[0]), .ifid_flush(ifid_flush[0]), .idex_bubble(idex_bubble[0]),
        .exmem_hold(exmem_hold[0]), .memwb_bubble(memwb_bubble[0]), .stall_active(stall_active[0])
`ifdef HAZARD_STATS_EN
        , .stall_cycles(stall_cycles[0]), .flush_count(flush_count[0])
`endif
    );

    hazard_ctrl #(.REG_AW(4), .LOAD_LAT(3), .R0_IS_ZERO(1'b1)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_valid(ex_valid),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_wr_en(ex_wr_en),
        .branch_taken(branch_taken), .mem_busy(mem_busy), .pc_hold(pc_hold[1]),
        .ifid_hold(ifid_hold[1]), .ifid_flush(ifid_flush[1]), .idex_bubble(idex_bubble[1]),
        .exmem_hold(exmem_hold[1]), .memwb_bubble(memwb_bubble[1]), .stall_active(stall_active[1])
`ifdef HAZARD_STATS_EN
        , .stall_cycles(stall_cycles[1]), .flush_count(flush_count[1])
`endif
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit load_use();
        return id_valid && ex_valid && ex_is_load && ex_wr_en && ex_rd != 4'd0 &&
               ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
    endfunction

    // {pc_hold, ifid_hold, ifid_flush, idex_bubble, exmem_hold, memwb_bubble, stall_active}
    function automatic logic [6:0] exp_outs(int k);
        logic sa;
        sa = waiting[k] || owed[k] > 0;
        if (!rst_n) return 7'b0;
        if (mem_busy) return {6'b110011, sa};
        if (branch_taken) return {6'b001100, sa};
        if (owed[k] > 0 || load_use()) return {6'b110100, sa};
        return {6'b000000, sa};
    endfunction

    function automatic logic [6:0] outs(int k);
        return {pc_hold[k], ifid_hold[k], ifid_flush[k], idex_bubble[k], exmem_hold[k], memwb_bubble[k], stall_active[k]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            owed[k] = 0;
            waiting[k] = 1'b0;
            stalls[k] = 0;
            flushes[k] = 0;
        end
    endtask

    task automatic drive(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                         input bit exv, input bit ld, input int rd, input bit wr, input bit br, input bit mb);
        id_valid = v;
        id_rs = 4'(rs);
        id_rt = 4'(rt);
        id_uses_rs = urs;
        id_uses_rt = urt;
        ex_valid = exv;
        ex_is_load = ld;
        ex_rd = 4'(rd);
        ex_wr_en = wr;
        branch_taken = br;
        mem_busy = mb;
    endtask

    task automatic idle();
        drive(1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic load_r5();
        drive(1, 5, 0, 1, 0, 1, 1, 5, 1, 0, 0);
    endtask

    // called at a falling edge after inputs are set: check, cross the rising edge, advance the model
    task automatic step(input string tag);
        logic [6:0] e [2];
        bit lu;
        #2;
        lu = load_use();
        for (int k = 0; k < 2; k++) begin
            e[k] = exp_outs(k);
            check($sformatf("%s lat%0d outs", tag, LAT[k]), 16'(outs(k)), 16'(e[k]));
`ifdef HAZARD_STATS_EN
            check($sformatf("%s lat%0d stall_cycles", tag, LAT[k]), stall_cycles[k], 16'(stalls[k]));
            check($sformatf("%s lat%0d flush_count", tag, LAT[k]), flush_count[k], 16'(flushes[k]));
`endif
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                owed[k] = 0;
                waiting[k] = 1'b0;
                stalls[k] = 0;
                flushes[k] = 0;
            end else begin
                if (e[k][6] && stalls[k] < 65535) stalls[k]++;
                if (e[k][4] && flushes[k] < 65535) flushes[k]++;
                if (mem_busy) waiting[k] = 1'b1;
                else begin
                    waiting[k] = 1'b0;
                    if (branch_taken) owed[k] = 0;
                    else if (owed[k] > 0) owed[k]--;
                    else if (lu) owed[k] = LAT[k] - 1;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        drive(1, 5, 5, 1, 1, 1, 1, 5, 1, 1, 1);
        step("reset");
        step("reset");
        rst_n = 1'b1;
        idle();
        step("idle");

        load_r5();
        step("lu_detect");
        idle();
        repeat (4) step("lu_drain");

        load_r5();
        step("br_detect");
        drive(1, 1, 2, 1, 1, 0, 0, 0, 0, 1, 0);
        step("br_in_stall");
        idle();
        repeat (3) step("br_after");

        load_r5();
        step("mw_detect");
        idle();
        step("mw_second");
        drive(1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 1);
        repeat (4) step("mw_freeze");
        idle();
        repeat (3) step("mw_resume");

        drive(1, 0, 0, 1, 1, 1, 1, 0, 1, 0, 0);
        step("r0_load");
        drive(1, 7, 7, 1, 1, 1, 0, 7, 1, 0, 0);
        step("alu_r7");

        drive(1, 1, 2, 1, 1, 0, 0, 0, 0, 1, 1);
        repeat (2) step("busy_and_branch");
        drive(1, 1, 2, 1, 1, 0, 0, 0, 0, 1, 0);
        step("branch_replayed");
        idle();
        step("idle2");

        repeat (400) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
            step("rand");
        end

        idle();
        step("pre_rst");
        load_r5();
        step("rst_detect");
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) check($sformatf("async_rst lat%0d outs", LAT[k]), 16'(outs(k)), 16'h0);
`ifdef HAZARD_STATS_EN
        for (int k = 0; k < 2; k++) check($sformatf("async_rst lat%0d stall_cycles", LAT[k]), stall_cycles[k], 16'h0);
`endif
        model_reset();
        @(negedge clk);
        step("in_rst");
        rst_n = 1'b1;
        repeat (2) step("post_rst");

`ifdef HAZARD_STATS_EN
        drive(1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 1);
        repeat (65540) step("sat");
        check("sat lat1 stall_cycles", stall_cycles[0], 16'hFFFF);
        idle();
        step("sat_exit");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
